perf_monitor: RTL and testbench

Synthesizable performance-monitor unit for the pipelined RISC-V core, the hardware successor to the bench-only cycle/instruction/branch counters. It taps the core's debug outputs and a vector of extra event strobes, and keeps a parametrised bank of saturating counters. Counting is governed by a start/stop/halt state machine, and any counter can be read back through a one-cycle-latency read port. It sits beside the core in the top level; results can be read by a bench or by on-chip logic without `real` arithmetic.

---
 rtl/perf_pkg.sv | 16 +
 rtl/perf_sat_counter.sv | 28 ++
 rtl/perf_monitor.sv | 112 +++++++++++
 tb/tb_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared state encoding and counter index map for the performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_e;

  localparam int unsigned CNT_CYCLE    = 0;
  localparam int unsigned CNT_INSN     = 1;
  localparam int unsigned CNT_CTRL     = 2;
  localparam int unsigned CNT_MISPRED  = 3;
  localparam int unsigned CNT_EVT_BASE = 4;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clr wins over counting.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && inc) begin
      // at all-ones the count holds and the saturation is recorded instead
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: start/stop/halt FSM gating a bank of saturating counters,
// with a registered one-cycle-latency read port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W      = 48,
  parameter int unsigned NUM_EVT    = 4,
  parameter logic [31:0] HALT_PC0   = 32'h1c,
  parameter logic [31:0] HALT_PC1   = 32'h20,
  parameter bit          AUTO_START = 1'b0,
  localparam int unsigned NUM_CNT   = 4 + NUM_EVT,
  localparam int unsigned SEL_W     = $clog2(NUM_CNT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_insn_vld,
  input  logic               i_ctrl,
  input  logic               i_mispred,
  input  logic [31:0]        i_pc_debug,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_clear,
  input  logic               i_rd_req,
  input  logic [SEL_W-1:0]   i_rd_sel,
  output logic               o_rd_vld,
  output logic [CNT_W-1:0]   o_rd_data,
  output logic [NUM_CNT-1:0] o_ovf,
  output logic [1:0]         o_state,
  output logic               o_done
);

  perf_state_e        state;
  logic               auto_pend;
  logic               halt_hit;
  logic               count_en;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-1:0]   rd_mux;

  assign halt_hit = i_insn_vld && ((i_pc_debug == HALT_PC0) || (i_pc_debug == HALT_PC1));
  assign count_en = (state == RUN) && !i_clear;
  assign o_state  = state;

  always_comb begin
    inc                             = '0;
    inc[CNT_CYCLE]                  = 1'b1;
    inc[CNT_INSN]                   = i_insn_vld;
    inc[CNT_CTRL]                   = i_ctrl;
    inc[CNT_MISPRED]                = i_mispred;
    inc[CNT_EVT_BASE +: NUM_EVT]    = i_evt;
  end

  // auto_pend is armed only by reset, so AUTO_START fires once per reset release
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      o_done    <= 1'b0;
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      if (i_clear) begin
        state  <= IDLE;
        o_done <= 1'b0;
      end else begin
        case (state)
          IDLE: if (i_start || auto_pend) state <= RUN;
          RUN: if (i_stop || halt_hit) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
          DONE: ;
          default: begin
            state  <= IDLE;
            o_done <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (i_clk),
      .rst_n (i_reset),
      .en    (count_en),
      .inc   (inc[g]),
      .clr   (i_clear),
      .cnt   (cnt[g]),
      .ovf   (o_ovf[g])
    );
  end

  // unmatched selects (>= NUM_CNT) fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (i_rd_sel == SEL_W'(i)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rd_vld  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_vld <= i_rd_req;
      if (i_rd_req) o_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: directed vector table, random run against a reference
// model, and a CNT_W=8 / AUTO_START instance for saturation and async reset.
module tb_perf_monitor;

  localparam longint unsigned MAX48 = 64'h0000_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, rst_sm_n;
  logic        insn, ctrl, mispred, start, stop, clear, rd_req;
  logic [31:0] pc;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;

  logic        rd_vld, done;
  logic [47:0] rd_data;
  logic [7:0]  ovf;
  logic [1:0]  state;

  logic        s_rd_vld, s_done;
  logic [7:0]  s_rd_data;
  logic [6:0]  s_ovf;
  logic [1:0]  s_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_monitor u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_insn_vld(insn), .i_ctrl(ctrl), .i_mispred(mispred),
    .i_pc_debug(pc), .i_evt(evt), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_rd_req(rd_req), .i_rd_sel(rd_sel), .o_rd_vld(rd_vld), .o_rd_data(rd_data),
    .o_ovf(ovf), .o_state(state), .o_done(done)
  );

  perf_monitor #(.CNT_W(8), .NUM_EVT(3), .AUTO_START(1'b1)) u_sm (
    .i_clk(clk), .i_reset(rst_sm_n), .i_insn_vld(insn), .i_ctrl(ctrl), .i_mispred(mispred),
    .i_pc_debug(pc), .i_evt(evt[2:0]), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_rd_req(rd_req), .i_rd_sel(rd_sel), .o_rd_vld(s_rd_vld), .o_rd_data(s_rd_data),
    .o_ovf(s_ovf), .o_state(s_state), .o_done(s_done)
  );

  typedef struct {
    logic        st, sp, cl, ins, ct;
    logic [31:0] pc;
    logic [3:0]  ev;
    logic        rq;
    logic [2:0]  sel;
    logic [1:0]  e_state;
    logic        e_done, e_vld;
    logic [47:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, sp, cl, ins, ct, input logic [31:0] pc_,
                              input logic [3:0] ev, input logic rq, input logic [2:0] sel,
                              input logic [1:0] es, input logic ed, evl, input logic [47:0] dat);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.ins = ins; v.ct = ct; v.pc = pc_; v.ev = ev;
    v.rq = rq; v.sel = sel; v.e_state = es; v.e_done = ed; v.e_vld = evl; v.e_data = dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    insn = 0; ctrl = 0; mispred = 0; start = 0; stop = 0; clear = 0;
    rd_req = 0; rd_sel = 0; pc = 32'h100; evt = 0;
  endtask

  // Reference model: counts held as plain integers, state as 0/1/2.
  longint unsigned m_cnt[8];
  logic [7:0]      m_ovf;
  int              m_state;
  logic            m_vld;
  longint unsigned m_data;

  task automatic model_reset();
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_ovf = '0; m_state = 0; m_vld = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit   halt;
    bit   strb[8];
    m_vld = rd_req;
    if (rd_req) m_data = m_cnt[rd_sel];
    halt = insn && (pc == 32'h1c || pc == 32'h20);
    strb[0] = 1; strb[1] = insn; strb[2] = ctrl; strb[3] = mispred;
    for (int k = 0; k < 4; k++) strb[4+k] = evt[k];
    if (clear) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_ovf = '0;
      m_state = 0;
    end else begin
      if (m_state == 1) begin
        for (int k = 0; k < 8; k++) begin
          if (strb[k]) begin
            if (m_cnt[k] == MAX48) m_ovf[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      if (m_state == 0 && start) m_state = 1;
      else if (m_state == 1 && (stop || halt)) m_state = 2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; rst_sm_n = 0;
    idle_inputs();
    #2;
    chk("reset_state", state, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_vld", rd_vld, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_ovf", ovf, 0);
    tick();
    rst_n = 1;

    // st sp cl ins ct pc ev rq sel | state done vld data
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h100,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,32'h100,0,1,0, 2,1,1,11));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,1, 2,1,1,7));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,2, 2,1,1,3));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,3, 2,1,1,0));
    tbl.push_back(mk(0,1,0,0,0,32'h100,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,32'h100,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h01c,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h020,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,1, 2,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,0, 2,1,1,2));
    tbl.push_back(mk(1,0,0,0,0,32'h100,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,32'h100,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,32'h100,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,1, 0,0,1,0));
    tbl.push_back(mk(1,0,1,0,0,32'h100,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,0, 0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,32'h100,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,1,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,1,1,4, 1,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,4, 1,0,1,2));
    tbl.push_back(mk(0,0,0,1,0,32'h01c,0,0,0, 2,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,1, 2,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,32'h100,0,1,0, 2,1,1,4));

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl; insn = tbl[i].ins;
      ctrl = tbl[i].ct; pc = tbl[i].pc; evt = tbl[i].ev; rd_req = tbl[i].rq; rd_sel = tbl[i].sel;
      tick();
      chk($sformatf("vec%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("vec%0d_rd_vld", i), rd_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].e_data);
      chk($sformatf("vec%0d_ovf", i), ovf, 0);
    end

    idle_inputs();
    clear = 1;
    tick();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      int r;
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 49) == 0);
      insn = 1'($urandom_range(0, 1));
      ctrl = 1'($urandom_range(0, 1));
      mispred = 1'($urandom_range(0, 1));
      evt = 4'($urandom_range(0, 15));
      rd_req = 1'($urandom_range(0, 1));
      rd_sel = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 19);
      pc = (r == 0) ? 32'h1c : (r == 1) ? 32'h20 : ($urandom | 32'h1000);
      model_step();
      tick();
      chk("rnd_state", state, 64'(m_state));
      chk("rnd_done", done, (m_state == 2) ? 1 : 0);
      chk("rnd_rd_vld", rd_vld, m_vld);
      if (m_vld) chk("rnd_rd_data", rd_data, m_data);
      chk("rnd_ovf", ovf, m_ovf);
    end

    idle_inputs();
    chk("sm_reset_state", s_state, 0);
    chk("sm_reset_ovf", s_ovf, 0);
    chk("sm_reset_rd_vld", s_rd_vld, 0);
    rst_sm_n = 1;
    tick();
    chk("sm_autostart", s_state, 1);
    repeat (300) tick();
    rd_req = 1; rd_sel = 0;
    tick();
    chk("sm_sat_vld", s_rd_vld, 1);
    chk("sm_sat_data", s_rd_data, 255);
    rd_sel = 7;
    tick();
    chk("sm_oob_vld", s_rd_vld, 1);
    chk("sm_oob_data", s_rd_data, 0);
    chk("sm_sat_ovf", s_ovf, 7'h01);
    rd_req = 0; clear = 1;
    tick();
    chk("sm_clear_state", s_state, 0);
    chk("sm_clear_ovf", s_ovf, 0);
    clear = 0; rd_req = 1; rd_sel = 0;
    tick();
    chk("sm_clear_data", s_rd_data, 0);
    chk("sm_no_reauto", s_state, 0);
    rd_req = 0; start = 1;
    tick();
    chk("sm_start", s_state, 1);
    start = 0;
    repeat (5) tick();
    rd_req = 1; rd_sel = 0;
    tick();
    chk("sm_midrun_data", s_rd_data, 5);
    rd_req = 0;
    #3 rst_sm_n = 0;
    #1;
    chk("sm_async_state", s_state, 0);
    chk("sm_async_done", s_done, 0);
    chk("sm_async_rd_vld", s_rd_vld, 0);
    chk("sm_async_rd_data", s_rd_data, 0);
    chk("sm_async_ovf", s_ovf, 0);
    #1 rst_sm_n = 1;
    tick();
    chk("sm_rerun_state", s_state, 1);
    rd_req = 1; rd_sel = 0;
    tick();
    chk("sm_restart0", s_rd_data, 0);
    tick();
    chk("sm_restart1", s_rd_data, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
